// File: rtl/gate_sensor_pkg.sv
// rtl/gate_sensor_pkg.sv - shared gate state encoding and sensor pattern constants
package gate_sensor_pkg;

    // Per-gate passage state. E* walk an entry, X* walk an exit.
    typedef enum logic [2:0] {
        S_IDLE,
        S_E1,
        S_E2,
        S_E3,
        S_X1,
        S_X2,
        S_X3,
        S_FAULT
    } gate_state_e;

    // Sensor patterns as {B, A}: A is the outer beam, B the inner beam.
    localparam logic [1:0] P_CLEAR = 2'b00;
    localparam logic [1:0] P_A     = 2'b01;
    localparam logic [1:0] P_BOTH  = 2'b11;
    localparam logic [1:0] P_B     = 2'b10;

endpackage

// File: rtl/gate_fsm.sv
// rtl/gate_fsm.sv - two-sensor passage recogniser for a single gate
//
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   synchronous active-low reset
//   pat      in   sensor pattern {B, A}, 1 = beam blocked
//   enter_o  out  registered one-cycle pulse per completed entry
//   exit_o   out  registered one-cycle pulse per completed exit
//   fault_o  out  registered level, high while the gate is in FAULT
module gate_fsm
    import gate_sensor_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pat,
    output logic       enter_o,
    output logic       exit_o,
    output logic       fault_o
);

    gate_state_e state_q, state_d;
    logic        enter_q, enter_d;
    logic        exit_q, exit_d;
    logic        fault_q, fault_d;

    // Each state accepts: its own pattern (hold), the pattern of the step
    // before it (back out one step), or the next pattern of its path.
    // Anything else is a fault.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pat == P_A)           state_d = S_E1;
                else if (pat == P_B)      state_d = S_X1;
                else if (pat == P_BOTH)   state_d = S_FAULT;
            end
            S_E1: begin
                if (pat == P_BOTH)        state_d = S_E2;
                else if (pat == P_CLEAR)  state_d = S_IDLE;
                else if (pat == P_B)      state_d = S_FAULT;
            end
            S_E2: begin
                if (pat == P_B)           state_d = S_E3;
                else if (pat == P_A)      state_d = S_E1;
                else if (pat == P_CLEAR)  state_d = S_FAULT;
            end
            S_E3: begin
                if (pat == P_CLEAR) begin
                    state_d = S_IDLE;
                    enter_d = 1'b1;
                end
                else if (pat == P_BOTH)   state_d = S_E2;
                else if (pat == P_A)      state_d = S_FAULT;
            end
            S_X1: begin
                if (pat == P_BOTH)        state_d = S_X2;
                else if (pat == P_CLEAR)  state_d = S_IDLE;
                else if (pat == P_A)      state_d = S_FAULT;
            end
            S_X2: begin
                if (pat == P_A)           state_d = S_X3;
                else if (pat == P_B)      state_d = S_X1;
                else if (pat == P_CLEAR)  state_d = S_FAULT;
            end
            S_X3: begin
                if (pat == P_CLEAR) begin
                    state_d = S_IDLE;
                    exit_d  = 1'b1;
                end
                else if (pat == P_BOTH)   state_d = S_X2;
                else if (pat == P_B)      state_d = S_FAULT;
            end
            default: begin
                if (pat == P_CLEAR)       state_d = S_IDLE;
            end
        endcase
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            fault_q <= fault_d;
        end
    end

    assign enter_o = enter_q;
    assign exit_o  = exit_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/gate_sensor_array.sv
// rtl/gate_sensor_array.sv - N two-sensor gates feeding a saturating occupancy counter
//
// Ports:
//   clk     in   clock, posedge
//   Rst     in   synchronous active-low reset
//   Sensor  in   2*N_GATES beams; gate g uses [2g+1:2g] = {B, A}
//   Enter   out  per-gate one-cycle entry pulse
//   Exit    out  per-gate one-cycle exit pulse
//   Fault   out  per-gate fault level
//   Count   out  current occupancy, saturating at 0 and CAPACITY
//   Full    out  Count == CAPACITY
//   Empty   out  Count == 0
//
// Optional build macro SENSOR_SYNC_EN: adds a two-flop synchroniser on every
// Sensor bit, delaying all outputs by two cycles.
module gate_sensor_array
    import gate_sensor_pkg::*;
#(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic [2*N_GATES-1:0]   Sensor,
    output logic [N_GATES-1:0]     Enter,
    output logic [N_GATES-1:0]     Exit,
    output logic [N_GATES-1:0]     Fault,
    output logic [CNT_W-1:0]       Count,
    output logic                   Full,
    output logic                   Empty
);

    logic [2*N_GATES-1:0] sens;

`ifdef SENSOR_SYNC_EN
    logic [2*N_GATES-1:0] sync1_q, sync1_d;
    logic [2*N_GATES-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = Sensor;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sens = sync2_q;
`else
    assign sens = Sensor;
`endif

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        gate_fsm u_gate (
            .clk     (clk),
            .rst_n   (Rst),
            .pat     (sens[2*g+1:2*g]),
            .enter_o (Enter[g]),
            .exit_o  (Exit[g]),
            .fault_o (Fault[g])
        );
    end

    logic [CNT_W-1:0] count_q, count_d;
    int               n_in, n_out, next_val;

    // Net change across all gates is applied at once, then clamped, so a
    // simultaneous entry and exit at the limit leaves the count unchanged.
    always_comb begin
        n_in  = 0;
        n_out = 0;
        for (int g = 0; g < N_GATES; g++) begin
            if (Enter[g]) n_in  = n_in + 1;
            if (Exit[g])  n_out = n_out + 1;
        end
        next_val = int'(count_q) + n_in - n_out;
        if (next_val > CAPACITY) next_val = CAPACITY;
        else if (next_val < 0)   next_val = 0;
        count_d = CNT_W'(next_val);
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;
    assign Full  = (count_q == CNT_W'(CAPACITY));
    assign Empty = (count_q == '0);

endmodule
